viterbi_frame_arbiter: RTL

Frame-level scheduler that time-shares one VITERBIDECODER instance between two coded-symbol requesters (channel 0, channel 1). For each granted frame it resets the decoder, feeds it FRAME_LEN code symbols paced by a symbol strobe, then flushes it with zero symbols. It captures the decoded bits and tags them with the channel number. It sits between the per-channel sync/buffer logic and the decoder, and replaces the simple Code!=0 Active synchronizer.

---
 rtl/viterbi_frame_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/viterbi_frame_arbiter.sv
// Frame scheduler that time-shares one Viterbi decoder between two symbol requesters.
// Each granted frame does a decoder reset, then a paced feed, then a zero-symbol flush.
module viterbi_frame_arbiter #(
    parameter int unsigned WD_CODE   = 2,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned DEC_LAT   = 48,
    parameter int unsigned SYM_DIV   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req0,
    input  logic               i_req1,
    input  logic [WD_CODE-1:0] i_code0,
    input  logic [WD_CODE-1:0] i_code1,
    output logic               o_gnt0,
    output logic               o_gnt1,
    output logic               o_sym_ack0,
    output logic               o_sym_ack1,
    output logic               o_dec_reset_n,
    output logic               o_dec_active,
    output logic [WD_CODE-1:0] o_dec_code,
    input  logic               i_dec_out,
    output logic               o_out_valid,
    output logic               o_out_data,
    output logic               o_out_ch,
    output logic               o_busy
);

    localparam int unsigned PW = $clog2(SYM_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RST   = 2'd1;
    localparam logic [1:0] S_FEED  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [PW-1:0] PH_LAST    = PW'(SYM_DIV - 1);
    localparam logic [10:0]   SYM_FEED_L = 11'(FRAME_LEN - 1);
    localparam logic [10:0]   SYM_FLSH_L = 11'(FRAME_LEN + DEC_LAT - 1);
    localparam logic [10:0]   SYM_CAP_LO = 11'(DEC_LAT);
    localparam logic [10:0]   SYM_CAP_HI = 11'(FRAME_LEN + DEC_LAT);

    logic [1:0]         r_state;
    logic [PW-1:0]      r_phase;
    logic [10:0]        r_sym;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_ch;
    logic               r_last;
    logic [WD_CODE-1:0] r_dec_code;
    logic               r_out_valid;
    logic               r_out_data;
    logic               r_out_ch;

    logic               w_running;
    logic               w_phase_zero;
    logic               w_phase_end;
    logic               w_capture;
    logic               w_pick;
    logic [WD_CODE-1:0] w_code_sel;

    assign w_running    = (r_state == S_FEED) || (r_state == S_FLUSH);
    assign w_phase_zero = (r_phase == '0);
    assign w_phase_end  = (r_phase == PH_LAST);
    // Decoded bits emerge only once the traceback window has filled.
    assign w_capture    = w_running && w_phase_end &&
                          (r_sym >= SYM_CAP_LO) && (r_sym < SYM_CAP_HI);
    assign w_pick       = (i_req0 && i_req1) ? ~r_last : i_req1;
    assign w_code_sel   = r_ch ? i_code1 : i_code0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_sym       <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_ch        <= 1'b0;
            r_last      <= 1'b1;
            r_dec_code  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;
            r_out_ch    <= 1'b0;
        end else begin
            r_out_valid <= w_capture;
            if (w_capture) begin
                r_out_data <= i_dec_out;
                r_out_ch   <= r_ch;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_state <= S_RST;
                        r_phase <= '0;
                        r_ch    <= w_pick;
                        r_gnt0  <= ~w_pick;
                        r_gnt1  <= w_pick;
                    end
                end
                S_RST: begin
                    if (w_phase_end) begin
                        r_state <= S_FEED;
                        r_phase <= '0;
                        r_sym   <= '0;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                S_FEED, S_FLUSH: begin
                    // Flush symbols are loaded on the same cadence so every symbol lasts one period.
                    if (w_phase_zero) begin
                        r_dec_code <= (r_state == S_FEED) ? w_code_sel : '0;
                    end
                    if (w_phase_end) begin
                        r_phase <= '0;
                        r_sym   <= r_sym + 11'd1;
                        if ((r_state == S_FEED) && (r_sym == SYM_FEED_L)) begin
                            r_state <= S_FLUSH;
                        end
                        if ((r_state == S_FLUSH) && (r_sym == SYM_FLSH_L)) begin
                            r_state <= S_IDLE;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                            r_last  <= r_ch;
                        end
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt0        = r_gnt0;
    assign o_gnt1        = r_gnt1;
    assign o_sym_ack0    = (r_state == S_FEED) && w_phase_zero && !r_ch;
    assign o_sym_ack1    = (r_state == S_FEED) && w_phase_zero && r_ch;
    assign o_dec_reset_n = w_running;
    assign o_dec_active  = w_running;
    assign o_dec_code    = r_dec_code;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_ch      = r_out_ch;
    assign o_busy        = (r_state != S_IDLE);

endmodule
